// File: rtl/nibble_serial_alu_ctrl_pkg.sv
// Shared encodings and saturation constants for the nibble-serial ALU controller.
package nibble_serial_alu_ctrl_pkg;

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_SUB    = 2'b01;
    localparam logic [1:0] OP_PADDSB = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [15:0] SAT16_MAX = 16'h7FFF;
    localparam logic [15:0] SAT16_MIN = 16'h8000;
    localparam logic [3:0]  SAT4_MAX  = 4'h7;
    localparam logic [3:0]  SAT4_MIN  = 4'h8;

    // Saturated nibble for a signed 4-bit overflow; the sign of A decides the rail.
    function automatic logic [3:0] sat_nibble(input logic a_sign);
        return a_sign ? SAT4_MIN : SAT4_MAX;
    endfunction

endpackage

// File: rtl/nibble_serial_alu_ctrl_cla.sv
// 4-bit carry-lookahead adder slice with group generate/propagate outputs.
module nibble_serial_alu_ctrl_cla (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    input  logic       sub,
    output logic [3:0] Sum,
    output logic       Ovfl,
    output logic       G_group,
    output logic       P_group
);

    logic [3:0] w_b;
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    // Lookahead carries, sum, signed overflow and group terms.
    always_comb begin
        w_b     = B ^ {4{sub}};
        w_g     = A & w_b;
        w_p     = A ^ w_b;
        w_c[0]  = Cin | sub;
        w_c[1]  = w_g[0] | (w_p[0] & w_c[0]);
        w_c[2]  = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
        w_c[3]  = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
        w_c[4]  = w_g[3] | (w_p[3] & w_c[3]);
        Sum     = w_p ^ w_c[3:0];
        Ovfl    = w_c[4] ^ w_c[3];
        G_group = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        P_group = &w_p;
    end

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// Multi-cycle saturating ADD/SUB/PADDSB unit sharing one 4-bit CLA over all nibbles.
module nibble_serial_alu_ctrl
    import nibble_serial_alu_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 flag_en,
    output logic                 flag_z,
    output logic                 flag_v,
    output logic                 flag_n
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e          r_state;
    state_e          w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic [1:0]      r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_work;
    logic [W-1:0]    r_result;
    logic            r_z;
    logic            r_v;
    logic            r_n;

    logic            w_is_sub;
    logic            w_is_paddsb;
    logic            w_last;
    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic            w_cin;
    logic [3:0]      w_sum;
    logic            w_ovfl;
    logic            w_gg;
    logic            w_pg;
    logic [3:0]      w_nib_out;
    logic [W-1:0]    w_work_next;
    logic [W-1:0]    w_final;

    // Word-level saturation rail chosen by the sign of operand A.
    function automatic logic [W-1:0] sat_word(input logic a_sign);
        return {a_sign, {(W-1){~a_sign}}};
    endfunction

    nibble_serial_alu_ctrl_cla u_cla (
        .A       (w_a_nib),
        .B       (w_b_nib),
        .Cin     (w_cin),
        .sub     (1'b0),
        .Sum     (w_sum),
        .Ovfl    (w_ovfl),
        .G_group (w_gg),
        .P_group (w_pg)
    );

    // Nibble select, operand conditioning, and final saturation of the working word.
    always_comb begin
        w_is_sub    = (r_op == OP_SUB);
        w_is_paddsb = (r_op == OP_PADDSB);
        w_last      = (r_cnt == CW'(NIBBLES - 1));
        w_a_nib     = r_a[4*r_cnt +: 4];
        w_b_nib     = w_is_sub ? ~r_b[4*r_cnt +: 4] : r_b[4*r_cnt +: 4];
        if (w_is_paddsb)
            w_cin = 1'b0;
        else if (r_cnt == '0)
            w_cin = w_is_sub;
        else
            w_cin = r_carry;
        w_nib_out   = (w_is_paddsb && w_ovfl) ? sat_nibble(w_a_nib[3]) : w_sum;
        w_work_next = r_work;
        w_work_next[4*r_cnt +: 4] = w_nib_out;
        w_final     = (!w_is_paddsb && w_ovfl) ? sat_word(r_a[W-1]) : w_work_next;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        done    = 1'b0;
        flag_en = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                flag_en = (r_op != OP_PADDSB);
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand latch, per-nibble accumulation, carry chaining and result/flag capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_z      <= 1'b0;
            r_v      <= 1'b0;
            r_n      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_cnt   <= '0;
                        r_carry <= 1'b0;
                        r_work  <= '0;
                    end
                end
                ST_RUN: begin
                    r_work  <= w_work_next;
                    r_carry <= w_gg | (w_pg & w_cin);
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_final;
                        if (!w_is_paddsb) begin
                            r_z <= (w_final == '0);
                            r_v <= w_ovfl;
                            r_n <= w_final[W-1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign flag_z = r_z;
    assign flag_v = r_v;
    assign flag_n = r_n;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Self-checking bench: directed and random operations against a word-level reference model.
module tb_nibble_serial_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        flag_en;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;

    int tests = 0;
    int fails = 0;

    // Reference model held state (what result/flags should currently show).
    logic [15:0] m_res;
    logic        m_z;
    logic        m_v;
    logic        m_n;

    nibble_serial_alu_ctrl #(.NIBBLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .flag_en (flag_en),
        .flag_z  (flag_z),
        .flag_v  (flag_v),
        .flag_n  (flag_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Signed 16-bit add/sub, clamped to the representable range.
    function automatic logic [16:0] ref_addsub(input logic [1:0] o, input logic [15:0] x,
                                               input logic [15:0] y);
        int sx;
        int sy;
        int r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = (o == 2'b01) ? sx - sy : sx + sy;
        if (r > 32767)       return {1'b1, 16'h7FFF};
        else if (r < -32768) return {1'b1, 16'h8000};
        else                 return {1'b0, 16'(r)};
    endfunction

    // Four independent signed nibble adds, each clamped to [-8, 7].
    function automatic logic [15:0] ref_paddsb(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] r;
        int s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = int'($signed(x[4*i +: 4])) + int'($signed(y[4*i +: 4]));
            if (s > 7)  s = 7;
            if (s < -8) s = -8;
            r[4*i +: 4] = 4'(s);
        end
        return r;
    endfunction

    // Issue one operation from a negedge, optionally poke start mid-run, and check completion.
    task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input bit poke);
        logic [16:0] vr;
        logic        en_exp;
        int          lat;
        if (o == 2'b10) begin
            m_res  = ref_paddsb(x, y);
            en_exp = 1'b0;
        end else begin
            vr     = ref_addsub(o, x, y);
            m_res  = vr[15:0];
            m_v    = vr[16];
            m_z    = (vr[15:0] == 16'h0000);
            m_n    = vr[15];
            en_exp = 1'b1;
        end
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        chk("busy_run", 16'(busy), 16'd1);
        chk("done_early", 16'(done), 16'd0);
        if (poke) begin
            start = 1'b1; op = 2'($urandom_range(0, 3)); a = ~x; b = y + 16'h1357;
            @(negedge clk);
            lat++;
            start = 1'b0;
        end
        while (done !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 16'(lat), 16'd5);
        chk("result", result, m_res);
        chk("flag_en", 16'(flag_en), 16'(en_exp));
        chk("flag_z", 16'(flag_z), 16'(m_z));
        chk("flag_v", 16'(flag_v), 16'(m_v));
        chk("flag_n", 16'(flag_n), 16'(m_n));
        @(negedge clk);
        chk("done_pulse", 16'(done), 16'd0);
        chk("busy_idle", 16'(busy), 16'd0);
        chk("result_hold", result, m_res);
    endtask

    logic [15:0] edge_vals [8] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000,
                                   16'hFFFF, 16'h8001, 16'h7FFE, 16'h0F0F};

    function automatic logic [15:0] pick();
        if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 7)];
        return 16'($urandom);
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        m_res = '0; m_z = 1'b0; m_v = 1'b0; m_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_result", result, 16'h0000);
        chk("rst_flags", {13'd0, flag_z, flag_v, flag_n}, 16'd0);
        chk("rst_flag_en", 16'(flag_en), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        do_op(2'b00, 16'h1234, 16'h0FF1, 1'b0);
        chk("add_exact", result, 16'h2225);
        do_op(2'b01, 16'h0005, 16'h0005, 1'b0);
        chk("sub_zero", 16'(flag_z), 16'd1);
        do_op(2'b01, 16'h0003, 16'h0005, 1'b0);
        chk("sub_neg", result, 16'hFFFE);
        do_op(2'b00, 16'h7FFF, 16'h0001, 1'b0);
        chk("add_sat", result, 16'h7FFF);
        do_op(2'b01, 16'h8000, 16'h0001, 1'b0);
        chk("sub_sat", result, 16'h8000);
        do_op(2'b10, 16'h781F, 16'h1F21, 1'b0);
        chk("paddsb_exact", result, 16'h7830);
        do_op(2'b11, 16'h4000, 16'h4000, 1'b0);
        do_op(2'b01, 16'h1000, 16'h2345, 1'b1);

        // Randomized operations, some mid-run start pokes.
        for (int i = 0; i < 40; i++)
            do_op(2'($urandom_range(0, 3)), pick(), pick(), ($urandom_range(0, 4) == 0));

        // Reset while the third nibble is being processed.
        start = 1'b1; op = 2'b00; a = 16'h1111; b = 16'h2222;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_res = '0; m_z = 1'b0; m_v = 1'b0; m_n = 1'b0;
        chk("midrst_busy", 16'(busy), 16'd0);
        chk("midrst_result", result, 16'h0000);
        chk("midrst_flags", {13'd0, flag_z, flag_v, flag_n}, 16'd0);
        for (int k = 0; k < 6; k++) begin
            chk("midrst_no_done", 16'(done), 16'd0);
            @(negedge clk);
        end

        // Fresh operation after reset.
        do_op(2'b00, 16'hFFFF, 16'h8000, 1'b0);
        do_op(2'b10, 16'h8877, 16'h8899, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
